// File: rtl/dcm_clkgen_prog_ctrl_if.sv
// Configuration request channel for dcm_clkgen_prog_ctrl.
//   cfg_m_m1  : requested M-1 (0 is illegal)
//   cfg_d_m1  : requested D-1
//   cfg_valid : request valid (requester -> controller)
//   cfg_ready : controller idle and able to take a request
// A request transfers on a clock edge where cfg_valid & cfg_ready are both high.
interface dcm_clkgen_prog_ctrl_if;
  localparam int unsigned CFG_W = 8;

  logic [CFG_W-1:0] cfg_m_m1;
  logic [CFG_W-1:0] cfg_d_m1;
  logic             cfg_valid;
  logic             cfg_ready;

  modport master (
    output cfg_m_m1,
    output cfg_d_m1,
    output cfg_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_m_m1,
    input  cfg_d_m1,
    input  cfg_valid,
    output cfg_ready
  );
endinterface

// File: rtl/dcm_clkgen_prog_ctrl.sv
// Drives the DCM_CLKGEN dynamic programming port (PROGEN/PROGDATA/PROGDONE).
// Takes one M/D request, shifts LoadD, LoadM and GO commands out LSB-first,
// then waits for PROGDONE and a synchronised LOCKED before reporting done.
// Ports:
//   clk, rst_n          : PROGCLK-domain clock (also feeds DCM PROGCLK), async active-low reset
//   cfg                 : request channel (slave modport), cfg_ready high only in IDLE
//   busy                : high in every state except IDLE
//   done / error        : one-cycle result pulses, never together
//   err_code            : 1 illegal M, 2 PROGDONE timeout, 3 lock timeout (valid with error)
//   cur_m_m1 / cur_d_m1 : M-1 / D-1 of the last successful program
//   prog_en / prog_data : to DCM PROGEN / PROGDATA
//   prog_done           : from DCM PROGDONE, already in clk domain
//   dcm_locked          : from DCM LOCKED, asynchronous
module dcm_clkgen_prog_ctrl #(
  parameter logic [7:0]  INIT_M_M1    = 8'd24,
  parameter logic [7:0]  INIT_D_M1    = 8'd0,
  parameter int unsigned DONE_TIMEOUT = 4095,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dcm_clkgen_prog_ctrl_if.slave cfg,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [7:0]            cur_m_m1,
  output logic [7:0]            cur_d_m1,
  output logic                  prog_en,
  output logic                  prog_data,
  input  logic                  prog_done,
  input  logic                  dcm_locked
);

  localparam int unsigned VAL_W  = 8;
  localparam int unsigned BIT_W  = 4;
  localparam int unsigned TMO_W  = 16;
  // A load burst is 2 command bits followed by 8 value bits.
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(9);
  localparam logic [TMO_W-1:0] DONE_LAST = TMO_W'(DONE_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] LOCK_LAST = TMO_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_D,
    S_GAP_D,
    S_LOAD_M,
    S_GAP_M,
    S_GO,
    S_WAIT_DONE,
    S_WAIT_LOCK
  } state_e;

  state_e             state_q, state_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [VAL_W-1:0]   m_q, m_d;
  logic [VAL_W-1:0]   d_q, d_d;
  logic [VAL_W-1:0]   cur_m_q, cur_m_d;
  logic [VAL_W-1:0]   cur_d_q, cur_d_d;
  logic               cfg_ready_q, cfg_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [1:0]         err_code_q, err_code_d;
  logic               prog_en_q, prog_en_d;
  logic               prog_data_q, prog_data_d;
  logic               lock_meta_q, lock_meta_d;
  logic               lock_sync_q, lock_sync_d;
  logic [BIT_W-1:0]   bit_nxt;

  // Serial bit idx of a load burst: 1, cmd_lo, then val[0]..val[7].
  function automatic logic ser_bit(input logic cmd_lo, input logic [VAL_W-1:0] val,
                                   input logic [BIT_W-1:0] idx);
    logic b;
    b = val[3'(idx - BIT_W'(2))];
    if (idx == BIT_W'(0)) begin
      b = 1'b1;
    end else if (idx == BIT_W'(1)) begin
      b = cmd_lo;
    end
    return b;
  endfunction

  // Next-state and registered-output decode; outputs are computed for the
  // state being entered so PROGEN/PROGDATA line up with the cycle numbering.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    m_d         = m_q;
    d_d         = d_q;
    cur_m_d     = cur_m_q;
    cur_d_d     = cur_d_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    err_code_d  = 2'd0;
    prog_en_d   = 1'b0;
    prog_data_d = 1'b0;
    lock_meta_d = dcm_locked;
    lock_sync_d = lock_meta_q;
    bit_nxt     = bit_cnt_q + BIT_W'(1);

    unique case (state_q)
      S_IDLE: begin
        if (cfg.cfg_valid && cfg_ready_q) begin
          m_d = cfg.cfg_m_m1;
          d_d = cfg.cfg_d_m1;
          if (cfg.cfg_m_m1 == VAL_W'(0)) begin
            error_d    = 1'b1;
            err_code_d = 2'd1;
          end else begin
            state_d     = S_LOAD_D;
            bit_cnt_d   = BIT_W'(0);
            prog_en_d   = 1'b1;
            prog_data_d = 1'b1;
          end
        end
      end
      S_LOAD_D: begin
        if (bit_cnt_q == LAST_BIT) begin
          state_d = S_GAP_D;
        end else begin
          bit_cnt_d   = bit_nxt;
          prog_en_d   = 1'b1;
          prog_data_d = ser_bit(1'b0, d_q, bit_nxt);
        end
      end
      S_GAP_D: begin
        state_d     = S_LOAD_M;
        bit_cnt_d   = BIT_W'(0);
        prog_en_d   = 1'b1;
        prog_data_d = 1'b1;
      end
      S_LOAD_M: begin
        if (bit_cnt_q == LAST_BIT) begin
          state_d = S_GAP_M;
        end else begin
          bit_cnt_d   = bit_nxt;
          prog_en_d   = 1'b1;
          prog_data_d = ser_bit(1'b1, m_q, bit_nxt);
        end
      end
      S_GAP_M: begin
        // GO command is a single PROGEN cycle with PROGDATA low.
        state_d   = S_GO;
        prog_en_d = 1'b1;
      end
      S_GO: begin
        state_d   = S_WAIT_DONE;
        tmo_cnt_d = TMO_W'(0);
      end
      S_WAIT_DONE: begin
        // PROGDONE takes priority over a coincident timeout.
        if (prog_done) begin
          state_d   = S_WAIT_LOCK;
          tmo_cnt_d = TMO_W'(0);
        end else if (tmo_cnt_q == DONE_LAST) begin
          state_d    = S_IDLE;
          error_d    = 1'b1;
          err_code_d = 2'd2;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      S_WAIT_LOCK: begin
        // LOCKED takes priority over a coincident timeout.
        if (lock_sync_q) begin
          state_d = S_IDLE;
          cur_m_d = m_q;
          cur_d_d = d_q;
          done_d  = 1'b1;
        end else if (tmo_cnt_q == LOCK_LAST) begin
          state_d    = S_IDLE;
          error_d    = 1'b1;
          err_code_d = 2'd3;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cfg_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers; reset drops PROGEN at once so a partial load
  // is never followed by GO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      m_q         <= '0;
      d_q         <= '0;
      cur_m_q     <= INIT_M_M1;
      cur_d_q     <= INIT_D_M1;
      cfg_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= 2'd0;
      prog_en_q   <= 1'b0;
      prog_data_q <= 1'b0;
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      m_q         <= m_d;
      d_q         <= d_d;
      cur_m_q     <= cur_m_d;
      cur_d_q     <= cur_d_d;
      cfg_ready_q <= cfg_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
      prog_en_q   <= prog_en_d;
      prog_data_q <= prog_data_d;
      lock_meta_q <= lock_meta_d;
      lock_sync_q <= lock_sync_d;
    end
  end

  assign cfg.cfg_ready = cfg_ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign err_code      = err_code_q;
  assign cur_m_m1      = cur_m_q;
  assign cur_d_m1      = cur_d_q;
  assign prog_en       = prog_en_q;
  assign prog_data     = prog_data_q;

endmodule
